// File: rtl/jt49_env_timer.sv
// JT49 envelope period timer: a fixed prescaler feeding a 16-bit period counter
// that toggles step on each period match, plus restart/null_period conditioning.
module jt49_env_timer #(
   parameter int PRE_W = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cen,
   input  logic [15:0] period,
   input  logic        env_wr,
   output logic        step,
   output logic        null_period,
   output logic        restart
);

   localparam logic [PRE_W-1:0] PRE_MAX = '1;

   logic [PRE_W-1:0] pre_cnt;
   logic [15:0]      per_cnt;
   logic             tick;
   logic [16:0]      per_next;
   logic             per_hit;

   // 17-bit compare so per_cnt+1 never wraps back below a large period
   always_comb begin
      tick     = cen && (pre_cnt == PRE_MAX);
      per_next = {1'b0, per_cnt} + 17'd1;
      per_hit  = per_next >= {1'b0, period};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         restart <= 1'b0;
      end else begin
         restart <= env_wr;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         null_period <= 1'b0;
      end else if (cen) begin
         null_period <= (period == 16'h0000);
      end
   end

   // A write to R13 clears the timer regardless of cen and beats a coincident tick
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_cnt <= '0;
         per_cnt <= 16'h0000;
         step    <= 1'b0;
      end else if (env_wr) begin
         pre_cnt <= '0;
         per_cnt <= 16'h0000;
         step    <= 1'b0;
      end else if (cen) begin
         pre_cnt <= pre_cnt + 1'b1;
         if (tick) begin
            if (per_hit) begin
               per_cnt <= 16'h0000;
               step    <= ~step;
            end else begin
               per_cnt <= per_next[15:0];
            end
         end
      end
   end

endmodule

// File: tb/tb_jt49_env_timer.sv
// Directed self-checking bench for jt49_env_timer with PRE_W=3 (8 cen per tick).
module tb_jt49_env_timer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cen = 1'b0;
   logic [15:0] period = 16'd0;
   logic        env_wr = 1'b0;
   logic        step;
   logic        null_period;
   logic        restart;

   logic        cen_on = 1'b1;
   logic        cen_div4 = 1'b0;
   logic [1:0]  ph = 2'd0;

   int checks = 0;
   int failures = 0;
   int n;

   jt49_env_timer #(.PRE_W(3)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cen         (cen),
      .period      (period),
      .env_wr      (env_wr),
      .step        (step),
      .null_period (null_period),
      .restart     (restart)
   );

   always #5 clk = ~clk;

   // cen changes on the falling edge, either steady or high one clk in four
   always @(negedge clk) begin
      ph  <= ph + 2'd1;
      cen <= cen_div4 ? (ph == 2'd0) : cen_on;
   end

   // Counts rising edges until step changes; n = -1 when limit expires
   task automatic wait_toggle(output int cnt, input int limit);
      logic start;
      start = step;
      cnt = 0;
      while (1) begin
         @(posedge clk);
         #1;
         cnt++;
         if (step !== start) break;
         if (cnt >= limit) begin
            cnt = -1;
            break;
         end
      end
   endtask

   task automatic do_restart();
      env_wr = 1'b1;
      @(posedge clk);
      #1;
      env_wr = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; cen_on = 1'b1; cen_div4 = 1'b0; period = 16'd5; env_wr = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (step !== 1'b0) begin failures++; $display("[TB] FAIL reset_step got=%b exp=0", step); end
      checks++; if (null_period !== 1'b0) begin failures++; $display("[TB] FAIL reset_null got=%b exp=0", null_period); end
      checks++; if (restart !== 1'b0) begin failures++; $display("[TB] FAIL reset_restart got=%b exp=0", restart); end
      rst_n = 1'b1;
      wait_toggle(n, 100);
      checks++; if (n !== 40) begin failures++; $display("[TB] FAIL reset_first_toggle got=%0d exp=40", n); end
   endtask

   task automatic test_cadence();
      period = 16'd3;
      do_restart();
      wait_toggle(n, 100);
      checks++; if (n !== 24) begin failures++; $display("[TB] FAIL cadence3_first got=%0d exp=24", n); end
      wait_toggle(n, 100);
      checks++; if (n !== 24) begin failures++; $display("[TB] FAIL cadence3_second got=%0d exp=24", n); end
      period = 16'hFFFF;
      do_restart();
      wait_toggle(n, 4000);
      checks++; if (n !== -1) begin failures++; $display("[TB] FAIL cadence_ffff_no_toggle got=%0d exp=-1", n); end
      period = 16'd1;
      wait_toggle(n, 100);
      checks++; if (n !== 8) begin failures++; $display("[TB] FAIL cadence_ffff_shrink got=%0d exp=8", n); end
   endtask

   task automatic test_cen_gating();
      period = 16'd2;
      cen_div4 = 1'b1;
      do_restart();
      wait_toggle(n, 300);
      checks++; if (step !== 1'b1) begin failures++; $display("[TB] FAIL cen_sync_step got=%b exp=1", step); end
      wait_toggle(n, 300);
      checks++; if (n !== 64) begin failures++; $display("[TB] FAIL cen_div4_a got=%0d exp=64", n); end
      wait_toggle(n, 300);
      checks++; if (n !== 64) begin failures++; $display("[TB] FAIL cen_div4_b got=%0d exp=64", n); end
      cen_div4 = 1'b0;
      cen_on = 1'b0;
      repeat (100) @(posedge clk);
      #1;
      checks++; if (step !== 1'b1) begin failures++; $display("[TB] FAIL cen_frozen_step got=%b exp=1", step); end
      do_restart();
      checks++; if (restart !== 1'b1) begin failures++; $display("[TB] FAIL cen_low_restart got=%b exp=1", restart); end
      checks++; if (step !== 1'b0) begin failures++; $display("[TB] FAIL cen_low_clear got=%b exp=0", step); end
      @(posedge clk);
      #1;
      checks++; if (restart !== 1'b0) begin failures++; $display("[TB] FAIL cen_low_restart_end got=%b exp=0", restart); end
      cen_on = 1'b1;
   endtask

   task automatic test_restart();
      period = 16'd3;
      do_restart();
      wait_toggle(n, 100);
      checks++; if (n !== 24 || step !== 1'b1) begin failures++; $display("[TB] FAIL rst_pre_toggle got=%0d/%b exp=24/1", n, step); end
      repeat (16) @(posedge clk);
      #1;
      do_restart();
      checks++; if (restart !== 1'b1) begin failures++; $display("[TB] FAIL restart_pulse got=%b exp=1", restart); end
      checks++; if (step !== 1'b0) begin failures++; $display("[TB] FAIL restart_clear_step got=%b exp=0", step); end
      @(posedge clk);
      #1;
      checks++; if (restart !== 1'b0) begin failures++; $display("[TB] FAIL restart_one_clk got=%b exp=0", restart); end
      wait_toggle(n, 100);
      checks++; if (n !== 23) begin failures++; $display("[TB] FAIL restart_realign got=%0d exp=23", n); end
      wait_toggle(n, 100);
      repeat (23) @(posedge clk);
      #1;
      do_restart();
      checks++; if (step !== 1'b0) begin failures++; $display("[TB] FAIL wr_vs_tick_step got=%b exp=0", step); end
      wait_toggle(n, 100);
      checks++; if (n !== 24) begin failures++; $display("[TB] FAIL wr_vs_tick_next got=%0d exp=24", n); end
   endtask

   task automatic test_back_to_back();
      env_wr = 1'b1;
      @(posedge clk);
      #1;
      checks++; if (restart !== 1'b1) begin failures++; $display("[TB] FAIL b2b_first got=%b exp=1", restart); end
      @(posedge clk);
      #1;
      env_wr = 1'b0;
      checks++; if (restart !== 1'b1) begin failures++; $display("[TB] FAIL b2b_second got=%b exp=1", restart); end
      @(posedge clk);
      #1;
      checks++; if (restart !== 1'b0) begin failures++; $display("[TB] FAIL b2b_end got=%b exp=0", restart); end
   endtask

   task automatic test_period_shrink();
      period = 16'd100;
      do_restart();
      repeat (400) @(posedge clk);
      #1;
      checks++; if (step !== 1'b0) begin failures++; $display("[TB] FAIL shrink_before got=%b exp=0", step); end
      period = 16'd10;
      wait_toggle(n, 100);
      checks++; if (n !== 8) begin failures++; $display("[TB] FAIL shrink_next_tick got=%0d exp=8", n); end
      wait_toggle(n, 200);
      checks++; if (n !== 80) begin failures++; $display("[TB] FAIL shrink_cadence got=%0d exp=80", n); end
   endtask

   task automatic test_null_period();
      period = 16'd0;
      @(posedge clk);
      #1;
      checks++; if (null_period !== 1'b1) begin failures++; $display("[TB] FAIL null_set got=%b exp=1", null_period); end
      do_restart();
      wait_toggle(n, 50);
      checks++; if (n !== 8) begin failures++; $display("[TB] FAIL null_toggle_a got=%0d exp=8", n); end
      wait_toggle(n, 50);
      checks++; if (n !== 8) begin failures++; $display("[TB] FAIL null_toggle_b got=%0d exp=8", n); end
      period = 16'd1;
      @(posedge clk);
      #1;
      checks++; if (null_period !== 1'b0) begin failures++; $display("[TB] FAIL null_clear got=%b exp=0", null_period); end
      do_restart();
      wait_toggle(n, 50);
      checks++; if (n !== 8) begin failures++; $display("[TB] FAIL p1_toggle got=%0d exp=8", n); end
      cen_on = 1'b0;
      @(posedge clk);
      #1;
      period = 16'd0;
      repeat (5) @(posedge clk);
      #1;
      checks++; if (null_period !== 1'b0) begin failures++; $display("[TB] FAIL null_held got=%b exp=0", null_period); end
      cen_on = 1'b1;
      @(posedge clk);
      #1;
      checks++; if (null_period !== 1'b1) begin failures++; $display("[TB] FAIL null_resume got=%b exp=1", null_period); end
   endtask

   task automatic test_async_reset();
      period = 16'd0;
      do_restart();
      wait_toggle(n, 50);
      checks++; if (step !== 1'b1 || null_period !== 1'b1) begin failures++; $display("[TB] FAIL areset_pre got=%b/%b exp=1/1", step, null_period); end
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (step !== 1'b0) begin failures++; $display("[TB] FAIL areset_step got=%b exp=0", step); end
      checks++; if (null_period !== 1'b0) begin failures++; $display("[TB] FAIL areset_null got=%b exp=0", null_period); end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      test_reset();
      test_cadence();
      test_cen_gating();
      test_restart();
      test_back_to_back();
      test_period_shrink();
      test_null_period();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
